// File: rtl/vid_mem_if.sv
// vid_mem_if: CPU-side byte bus of the QL screen memory.
//   master modport : drives cpu_addr/cpu_din/cpu_we/cpu_req, receives cpu_hit/cpu_dout/cpu_ack
//   slave modport  : the mirror image, used by vid_mem
// Handshake: the master raises cpu_req (level) with stable addr/we/din and keeps it high
// until it sees the one-cycle cpu_ack pulse. It then drops cpu_req before the next request.
interface vid_mem_if;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic        cpu_req;
    logic        cpu_hit;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;

    modport master (
        output cpu_addr, cpu_din, cpu_we, cpu_req,
        input  cpu_hit, cpu_dout, cpu_ack
    );

    modport slave (
        input  cpu_addr, cpu_din, cpu_we, cpu_req,
        output cpu_hit, cpu_dout, cpu_ack
    );
endinterface

// File: rtl/vid_mem.sv
// vid_mem: QL screen memory on a true dual-port RAM.
//   Port A : CPU byte reads and writes through vid_mem_if (req/ack), plus the clear engine.
//   Port B : scanout word reads, fixed 1-cycle registered latency, never stalls.
// Ports:
//   clk, reset (sync, active-high)
//   cpu      vid_mem_if.slave  CPU byte bus; cpu_hit is combinational address decode
//   vid_addr in  [AW-1:0]      scanout word address
//   vid_dout out [15:0]        scanout word, even byte in [15:8]
//   scr_sel  in                displayed screen select (SCREEN2_EN only)
//   busy     out               high while the memory is being zero-filled
// Build option: define SCREEN2_EN for a second 32 KB screen at SCR_BASE+20'h8000
// (32K words, video index {scr_sel, vid_addr}).
module vid_mem #(
    parameter logic [19:0]  SCR_BASE = 20'h20000,
    parameter int unsigned  AW       = 14
) (
    input  logic            clk,
    input  logic            reset,
    vid_mem_if.slave        cpu,
    input  logic [AW-1:0]   vid_addr,
    output logic [15:0]     vid_dout,
    input  logic            scr_sel,
    output logic            busy
);

`ifdef SCREEN2_EN
    localparam int unsigned RAW = AW + 1;
    localparam logic [19:0] WIN = 20'h10000;
`else
    localparam int unsigned RAW = AW;
    localparam logic [19:0] WIN = 20'h08000;
`endif
    localparam int unsigned DEPTH = 1 << RAW;

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_ACK, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [RAW-1:0]   cnt_q, cnt_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic [15:0]      vid_dout_q;

    logic [15:0]      mem [DEPTH];
    logic [15:0]      a_rdata_q;
    logic [RAW-1:0]   a_addr;
    logic [15:0]      a_wdata;
    logic             a_we_hi, a_we_lo;
    logic             mem_we_hi, mem_we_lo;

    logic [RAW-1:0]   cpu_widx;
    logic [RAW-1:0]   vid_widx;
    logic [19:0]      cpu_off;

    // Offset wraps for addresses below SCR_BASE, so one unsigned compare covers both bounds.
    assign cpu_off     = cpu.cpu_addr - SCR_BASE;
    assign cpu.cpu_hit = (cpu_off < WIN);

`ifdef SCREEN2_EN
    assign cpu_widx = {cpu.cpu_addr[AW+1], cpu.cpu_addr[AW:1]};
    assign vid_widx = {scr_sel, vid_addr};
`else
    logic unused_scr_sel;
    assign unused_scr_sel = scr_sel;
    assign cpu_widx = cpu.cpu_addr[AW:1];
    assign vid_widx = vid_addr;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpu_dout_d = cpu_dout_q;
        a_addr     = cpu_widx;
        a_wdata    = {cpu.cpu_din, cpu.cpu_din};
        a_we_hi    = 1'b0;
        a_we_lo    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                a_addr  = cnt_q;
                a_wdata = '0;
                a_we_hi = 1'b1;
                a_we_lo = 1'b1;
                cnt_d   = cnt_q + RAW'(1);
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cpu.cpu_req && cpu.cpu_hit) begin
                    if (cpu.cpu_we) begin
                        a_we_hi = ~cpu.cpu_addr[0];
                        a_we_lo =  cpu.cpu_addr[0];
                        state_d = S_ACK;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                cpu_dout_d = cpu.cpu_addr[0] ? a_rdata_q[7:0] : a_rdata_q[15:8];
                state_d    = S_ACK;
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!cpu.cpu_req) state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // No RAM write may land on a reset edge: an in-flight access is dropped.
    assign mem_we_hi = a_we_hi & ~reset;
    assign mem_we_lo = a_we_lo & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            cpu_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Port A: byte-enabled write, read-before-write registered read.
    always_ff @(posedge clk) begin
        if (mem_we_hi) mem[a_addr][15:8] <= a_wdata[15:8];
        if (mem_we_lo) mem[a_addr][7:0]  <= a_wdata[7:0];
        a_rdata_q <= mem[a_addr];
    end

    // Port B: scanout read; sees old data on a same-cycle port A write.
    always_ff @(posedge clk) begin
        if (reset) vid_dout_q <= '0;
        else       vid_dout_q <= mem[vid_widx];
    end

    assign cpu.cpu_dout = cpu_dout_q;
    assign cpu.cpu_ack  = (state_q == S_ACK);
    assign vid_dout     = vid_dout_q;
    assign busy         = (state_q == S_CLEAR);

endmodule

// File: tb/tb_vid_mem.sv
// tb_vid_mem: directed self-checking bench for vid_mem (default build or SCREEN2_EN).
module tb_vid_mem;
`ifdef SCREEN2_EN
    localparam int CLEAR_CYCLES = 32768;
`else
    localparam int CLEAR_CYCLES = 16384;
`endif

    logic        clk;
    logic        reset;
    logic [13:0] vid_addr;
    logic [15:0] vid_dout;
    logic        scr_sel;
    logic        busy;

    int errors;
    int checks;

    vid_mem_if bus();

    vid_mem #(.SCR_BASE(20'h20000), .AW(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (bus),
        .vid_addr (vid_addr),
        .vid_dout (vid_dout),
        .scr_sel  (scr_sel),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic vid_read(input logic [13:0] a, output logic [15:0] d);
        vid_addr = a;
        @(negedge clk);
        d = vid_dout;
    endtask

    task automatic cpu_txn(input logic [19:0] addr, input logic we, input logic [7:0] din,
                           input int hold_extra, output int lat, output logic [7:0] dout,
                           output int extra_acks);
        bus.cpu_addr = addr;
        bus.cpu_we   = we;
        bus.cpu_din  = din;
        bus.cpu_req  = 1'b1;
        lat = 0;
        extra_acks = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.cpu_ack && lat < 100);
        dout = bus.cpu_dout;
        repeat (hold_extra) begin
            @(negedge clk);
            if (bus.cpu_ack) extra_acks++;
        end
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          extra;
        int          n;
        logic [7:0]  d8;
        logic [15:0] d16;

        errors = 0;
        checks = 0;
        reset = 1'b1;
        scr_sel = 1'b0;
        vid_addr = '0;
        bus.cpu_addr = '0;
        bus.cpu_din = '0;
        bus.cpu_we = 1'b0;
        bus.cpu_req = 1'b0;

        // 1. reset state and clear duration
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ack", bus.cpu_ack, 0);
        check("rst_cpu_dout", bus.cpu_dout, 0);
        check("rst_vid_dout", vid_dout, 0);
        reset = 1'b0;
        n = 0;
        while (busy && n < 40000) begin
            n++;
            @(negedge clk);
        end
        check("clear_cycles", n, CLEAR_CYCLES);
        vid_read(14'h0000, d16); check("sweep_0", d16, 16'h0000);
        vid_read(14'h0001, d16); check("sweep_1", d16, 16'h0000);
        vid_read(14'h1234, d16); check("sweep_1234", d16, 16'h0000);
        vid_read(14'h3FFF, d16); check("sweep_3fff", d16, 16'h0000);
`ifdef SCREEN2_EN
        scr_sel = 1'b1;
        vid_read(14'h3FFF, d16); check("sweep_s1_3fff", d16, 16'h0000);
        scr_sel = 1'b0;
`endif

        // 2. byte writes and video readback
        cpu_txn(20'h20000, 1'b1, 8'hA5, 0, lat, d8, extra);
        check("wr_lat_even", lat, 1);
        cpu_txn(20'h20001, 1'b1, 8'h3C, 0, lat, d8, extra);
        check("wr_lat_odd", lat, 1);
        vid_read(14'h0000, d16); check("vid_word0", d16, 16'hA53C);

        // 3. read at the top of the window, held request gives a single ack
        cpu_txn(20'h27FFF, 1'b1, 8'h81, 0, lat, d8, extra);
        cpu_txn(20'h27FFF, 1'b0, 8'h00, 5, lat, d8, extra);
        check("rd_lat", lat, 2);
        check("rd_data_81", d8, 8'h81);
        check("rd_no_double_ack", extra, 0);
        cpu_txn(20'h20000, 1'b0, 8'h00, 0, lat, d8, extra);
        check("rd_data_a5", d8, 8'hA5);
        cpu_txn(20'h20001, 1'b0, 8'h00, 0, lat, d8, extra);
        check("rd_data_3c", d8, 8'h3C);

        // 4. address decode boundaries; a miss is ignored
        bus.cpu_addr = 20'h18000; #1;
        check("hit_18000", bus.cpu_hit, 0);
        bus.cpu_addr = 20'h1FFFF; #1;
        check("hit_1ffff", bus.cpu_hit, 0);
        bus.cpu_addr = 20'h27FFF; #1;
        check("hit_27fff", bus.cpu_hit, 1);
        bus.cpu_addr = 20'h28000; #1;
`ifdef SCREEN2_EN
        check("hit_28000", bus.cpu_hit, 1);
`else
        check("hit_28000", bus.cpu_hit, 0);
`endif
        bus.cpu_addr = 20'h18000;
        bus.cpu_we = 1'b1;
        bus.cpu_req = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cpu_ack) extra++;
        end
        check("miss_no_ack", extra, 0);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // 5. same-cycle write and video read of one word
        cpu_txn(20'h20003, 1'b1, 8'h12, 0, lat, d8, extra);
        bus.cpu_addr = 20'h20002;
        bus.cpu_we = 1'b1;
        bus.cpu_din = 8'hFF;
        bus.cpu_req = 1'b1;
        vid_addr = 14'h0001;
        @(negedge clk);
        check("rbw_old", vid_dout, 16'h0012);
        check("rbw_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rbw_new", vid_dout, 16'hFF12);
        @(negedge clk);

        // 6. reset in RD drops the read; a request during clear waits for it
        bus.cpu_addr = 20'h20000;
        bus.cpu_we = 1'b0;
        bus.cpu_req = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rst_rd_no_ack", bus.cpu_ack, 0);
        check("rst_rd_busy", busy, 1);
        @(negedge clk);
        check("rst_rd_no_ack2", bus.cpu_ack, 0);
        reset = 1'b0;
        bus.cpu_addr = 20'h20010;
        bus.cpu_we = 1'b1;
        bus.cpu_din = 8'h77;
        bus.cpu_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.cpu_ack && lat < 40000);
        check("busy_req_lat", lat, CLEAR_CYCLES + 1);
        check("busy_req_busy", busy, 0);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        vid_read(14'h0000, d16); check("recleared_w0", d16, 16'h0000);
        vid_read(14'h0008, d16); check("busy_wr_w8", d16, 16'h7700);

`ifdef SCREEN2_EN
        cpu_txn(20'h28000, 1'b1, 8'h5A, 0, lat, d8, extra);
        check("s1_wr_lat", lat, 1);
        scr_sel = 1'b1;
        vid_read(14'h0000, d16); check("s1_word0", d16, 16'h5A00);
        scr_sel = 1'b0;
        vid_read(14'h0000, d16); check("s0_word0", d16, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
